xm_stage_register: RTL
======================

# xm_stage_register

Parametrised EX/MEM stage register with an elastic valid/ready handshake, a one-entry skid slot, and synchronous flush. It sits between the execute and memory stages and carries the ALU result, zero flag, jump target, destination register, and the five memory/writeback control bits. Unlike a plain clocked register, it absorbs a downstream stall without combinational ready paths. It also kills in-flight instructions on a branch flush and forces bubble control bits to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, width of alu_result and jump_result
- REG_ADDR_WIDTH, 5, width of write_reg_addr

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  execute stage presents an entry
- in_ready  out  1  register can accept; registered, equals !skid_valid
- in_alu_result  in  DATA_WIDTH  ALU result
- in_alu_zero  in  1  ALU zero flag
- in_jump_result  in  DATA_WIDTH  branch/jump target
- in_write_reg_addr  in  REG_ADDR_WIDTH  destination register
- in_mem_read, in_mem_write, in_mem_reg, in_branch, in_reg_write  in  1 each  control bits
- out_valid  out  1  entry held in main slot
- out_ready  in  1  memory stage consumes the entry this cycle
- out_alu_result, out_alu_zero, out_jump_result, out_write_reg_addr  out  as inputs  main-slot payload
- out_mem_read, out_mem_write, out_mem_reg, out_branch, out_reg_write  out  1 each  main-slot control bits, ANDed with out_valid
- out_branch_taken  out  1  out_branch & out_alu_zero & out_valid
- occupancy  out  2  entries held: 0, 1 or 2

## Operation
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Storage: a main slot, which drives the outputs, and a skid slot. Each slot has a valid bit.
- State encoding follows occupancy: EMPTY (0), HALF (main only), FULL (main and skid).
- Accept is in_valid & in_ready. Drain is out_valid & out_ready.
- EMPTY: accept moves the entry to main, then HALF.
- HALF:
  - Accept without drain moves the entry to skid, then FULL.
  - Accept with drain moves the entry to main and stays HALF.
  - Drain without accept goes to EMPTY.
- FULL: in_ready is 0. Drain moves skid into main, then HALF. Otherwise it holds.
- flush wins over everything. Next state is EMPTY, both valid bits clear, and the input is not captured that cycle. in_ready returns to 1 on the next cycle.
- Payload registers load only on capture. When invalid, payload outputs hold stale data, but all control outputs and out_branch_taken are 0.
- Widths pass through unchanged. No arithmetic is performed.

## Timing
- Reset: every output is 0 except in_ready, which is 1. Payload and valid registers clear asynchronously.
- Reset asserted mid-operation discards all entries immediately.
- Latency: entry accepted at edge N appears on out_* after edge N, 1 cycle.
- Throughput: 1 entry per cycle while out_ready stays high.
- in_ready is registered. It drops the cycle after FULL is entered and rises the cycle after the skid slot drains.
- No combinational path from out_ready to in_ready.
- Order is preserved: the skid entry is always older than any new input.
- in_valid while in_ready=0 is ignored. Upstream holds its entry.
- flush together with drain: the drained entry counts as consumed downstream. All remaining entries are killed.

## Structure
- Shared package xm_pkg holds the default width constants and a packed struct xm_payload_t containing all payload and control fields. Both slots store this struct.
- Sub-module xm_slot is natural: one payload register plus valid bit, with load, clear and async reset. Instantiate it twice.
- State is derived from the two valid bits. No separate state register.

## Test plan
- Reset: hold rst_n=0 mid-stream -> out_valid=0, occupancy=0, in_ready=1, out_reg_write=0, all payload outputs 0.
- Streaming: out_ready=1, feed 4 entries with alu_result 0x10..0x13 -> same values appear one cycle later, back to back, occupancy stays 1.
- Stall: drop out_ready with 0x20 held and present 0x21 -> occupancy=2, in_ready=0 next cycle. 0x22 is held off. Raise out_ready -> outputs 0x20, 0x21, 0x22 in order.
- Flush: with FULL state and in_valid=1, pulse flush -> next cycle occupancy=0, out_valid=0, out_mem_write=0, in_ready=1. The flushed input never appears.
- Branch: entry with branch=1, alu_zero=1 -> out_branch_taken=1. Same entry with alu_zero=0 -> 0. Bubble with stale branch payload -> 0.
- Parameters: DATA_WIDTH=64, REG_ADDR_WIDTH=6, alu_result 0xFFFF_0000_1234_5678, reg 63 -> passes unchanged.

Source files
------------

// File: rtl/xm_pkg.sv
// Shared definitions for the EX/MEM stage register: default widths, slot
// state codes and the payload record carried through both storage slots.
package xm_pkg;

    localparam int XM_DATA_WIDTH     = 32;
    localparam int XM_REG_ADDR_WIDTH = 5;

    // State is {skid_valid, main_valid}; the skid slot is never valid alone.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_HALF  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_reg;
        logic branch;
        logic reg_write;
    } xm_ctrl_t;

    typedef struct packed {
        logic [XM_DATA_WIDTH-1:0]     alu_result;
        logic                         alu_zero;
        logic [XM_DATA_WIDTH-1:0]     jump_result;
        logic [XM_REG_ADDR_WIDTH-1:0] write_reg_addr;
        xm_ctrl_t                     ctrl;
    } xm_payload_t;

endpackage

// File: rtl/xm_slot.sv
// One storage slot: a payload register plus valid bit. Clear only drops the
// valid bit so the payload stays visible (stale) on the outputs.
module xm_slot
    import xm_pkg::*;
#(
    parameter type T = xm_payload_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic clear_i,
    input  T     data_i,
    output logic valid_o,
    output T     data_o
);

    logic valid_q;
    T     data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/xm_stage_register.sv
// EX/MEM pipeline register with a registered-ready elastic handshake, a one
// entry skid slot and a synchronous flush that kills every held entry.
module xm_stage_register
    import xm_pkg::*;
#(
    parameter int DATA_WIDTH     = XM_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = XM_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic                      in_alu_zero,
    input  logic [DATA_WIDTH-1:0]     in_jump_result,
    input  logic [REG_ADDR_WIDTH-1:0] in_write_reg_addr,
    input  logic                      in_mem_read,
    input  logic                      in_mem_write,
    input  logic                      in_mem_reg,
    input  logic                      in_branch,
    input  logic                      in_reg_write,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_alu_result,
    output logic                      out_alu_zero,
    output logic [DATA_WIDTH-1:0]     out_jump_result,
    output logic [REG_ADDR_WIDTH-1:0] out_write_reg_addr,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      out_mem_reg,
    output logic                      out_branch,
    output logic                      out_reg_write,
    output logic                      out_branch_taken,
    output logic [1:0]                occupancy
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu_result;
        logic                      alu_zero;
        logic [DATA_WIDTH-1:0]     jump_result;
        logic [REG_ADDR_WIDTH-1:0] write_reg_addr;
        xm_ctrl_t                  ctrl;
    } payload_t;

    payload_t   in_payload;
    payload_t   main_data, skid_data, main_d;
    logic       main_valid, skid_valid;
    logic       main_load, main_clear, skid_load, skid_clear;
    logic       accept, drain;
    logic [1:0] state;

    assign in_payload.alu_result      = in_alu_result;
    assign in_payload.alu_zero        = in_alu_zero;
    assign in_payload.jump_result     = in_jump_result;
    assign in_payload.write_reg_addr  = in_write_reg_addr;
    assign in_payload.ctrl.mem_read   = in_mem_read;
    assign in_payload.ctrl.mem_write  = in_mem_write;
    assign in_payload.ctrl.mem_reg    = in_mem_reg;
    assign in_payload.ctrl.branch     = in_branch;
    assign in_payload.ctrl.reg_write  = in_reg_write;

    // in_ready comes straight from the skid valid flop, so out_ready never
    // reaches it combinationally.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid & out_ready;
    assign state    = {skid_valid, main_valid};

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = in_payload;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_HALF: begin
                    if (accept && !drain) begin
                        skid_load = 1'b1;
                    end else if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (drain) begin
                        main_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_load  = 1'b1;
                        main_d     = skid_data;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    xm_slot #(.T(payload_t)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_d),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    xm_slot #(.T(payload_t)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_payload),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    assign out_valid          = main_valid;
    assign out_alu_result     = main_data.alu_result;
    assign out_alu_zero       = main_data.alu_zero;
    assign out_jump_result    = main_data.jump_result;
    assign out_write_reg_addr = main_data.write_reg_addr;
    assign out_mem_read       = main_data.ctrl.mem_read  & main_valid;
    assign out_mem_write      = main_data.ctrl.mem_write & main_valid;
    assign out_mem_reg        = main_data.ctrl.mem_reg   & main_valid;
    assign out_branch         = main_data.ctrl.branch    & main_valid;
    assign out_reg_write      = main_data.ctrl.reg_write & main_valid;
    assign out_branch_taken   = main_data.ctrl.branch & main_data.alu_zero & main_valid;
    assign occupancy          = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
